// File: rtl/alu16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu16_pkg
// Description : Shared constants for the registered 16-bit ALU: default
//               datapath width and the 4-bit operation codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu16_pkg;

    localparam int ALU_WIDTH = 16;

    typedef logic [3:0] opcode_t;

    localparam opcode_t OP_NOOP  = 4'h0;
    localparam opcode_t OP_AND   = 4'h1;
    localparam opcode_t OP_OR    = 4'h2;
    localparam opcode_t OP_XOR   = 4'h3;
    localparam opcode_t OP_ADD   = 4'h4;
    localparam opcode_t OP_MUL   = 4'h5;
    localparam opcode_t OP_SRL   = 4'h6;
    localparam opcode_t OP_NOT   = 4'h7;
    localparam opcode_t OP_MOD   = 4'h8;
    localparam opcode_t OP_NAND  = 4'h9;
    localparam opcode_t OP_NOR   = 4'hA;
    localparam opcode_t OP_XNOR  = 4'hB;
    localparam opcode_t OP_SUB   = 4'hC;
    localparam opcode_t OP_DIV   = 4'hD;
    localparam opcode_t OP_SLL   = 4'hE;
    localparam opcode_t OP_CLEAR = 4'hF;

endpackage
`default_nettype wire

// File: rtl/alu16_if.sv
`default_nettype none
// ============================================================================
// Module      : alu16_if
// Description : Operand/opcode inputs and registered/result outputs of the
//               ALU core. The master drives operands, the slave is the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu16_if
    import alu16_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       select;
    logic [WIDTH-1:0] final_output;
    logic [WIDTH-1:0] prev_output;
    logic             error;

    modport master (
        output a_in, b_in, opcode,
        input  a, b, select, final_output, prev_output, error
    );

    modport slave (
        input  a_in, b_in, opcode,
        output a, b, select, final_output, prev_output, error
    );

endinterface
`default_nettype wire

// File: rtl/alu16_datapath.sv
`default_nettype none
// ============================================================================
// Module      : alu16_datapath
// Description : Purely combinational 16-way ALU operation and error select.
//               Division/modulus use a restoring array so no divide operator
//               sits on the timing path.
// Revision    : 1.0 - initial release
// ============================================================================
module alu16_datapath
    import alu16_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  wire  [WIDTH-1:0] i_a,
    input  wire  [WIDTH-1:0] i_b,
    input  wire  [3:0]       i_select,
    input  wire  [WIDTH-1:0] i_prev,
    output logic [WIDTH-1:0] o_result,
    output logic             o_error
);

    localparam int SHW = $clog2(WIDTH);

    // Shared adder: select[3] distinguishes SUB (4'hC) from ADD (4'h4).
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;

    assign w_sub   = i_select[3];
    assign w_sum   = {1'b0, i_a} + {1'b0, i_b ^ {WIDTH{w_sub}}} + {{WIDTH{1'b0}}, w_sub};
    assign w_carry = w_sum[WIDTH];

    // Full-width product so overflow can be flagged from the upper half.
    logic [2*WIDTH-1:0] w_prod;
    assign w_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // Only the low log2(WIDTH) bits of b act as shift amount.
    logic [SHW-1:0] w_shamt;
    assign w_shamt = i_b[SHW-1:0];

    // Restoring divider: one row per quotient bit, MSB first.
    logic [WIDTH-1:0] w_rem [0:WIDTH];
    logic [WIDTH-1:0] w_quo;

    assign w_rem[0] = '0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_div_row
            logic [WIDTH:0]   w_shift;
            logic [WIDTH-1:0] w_diff;
            logic             w_ge;

            assign w_shift = {w_rem[gi], i_a[WIDTH-1-gi]};
            assign w_ge    = (w_shift >= {1'b0, i_b});
            // When w_ge holds the true difference is below b, so the low bits are exact.
            assign w_diff  = w_shift[WIDTH-1:0] - i_b;
            assign w_quo[WIDTH-1-gi] = w_ge;
            assign w_rem[gi+1]       = w_ge ? w_diff : w_shift[WIDTH-1:0];
        end
    endgenerate

    logic w_b_zero;
    assign w_b_zero = (i_b == '0);

    // Operation and error select; every select value decodes to a defined result.
    always_comb begin
        o_result = '0;
        o_error  = 1'b0;
        case (i_select)
            OP_NOOP:  o_result = i_prev;
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_NAND:  o_result = ~(i_a & i_b);
            OP_NOR:   o_result = ~(i_a | i_b);
            OP_XNOR:  o_result = ~(i_a ^ i_b);
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_error  = w_carry;
            end
            OP_SUB: begin
                o_result = w_sum[WIDTH-1:0];
                o_error  = ~w_carry;
            end
            OP_MUL: begin
                o_result = w_prod[WIDTH-1:0];
                o_error  = |w_prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                o_result = w_b_zero ? '0 : w_quo;
                o_error  = w_b_zero;
            end
            OP_MOD: begin
                o_result = w_b_zero ? '0 : w_rem[WIDTH];
                o_error  = w_b_zero;
            end
            OP_SRL:   o_result = i_a >> w_shamt;
            OP_SLL:   o_result = i_a << w_shamt;
            OP_NOT:   o_result = ~i_a;
            OP_CLEAR: o_result = '0;
            default: begin
                o_result = '0;
                o_error  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu16_core.sv
`default_nettype none
// ============================================================================
// Module      : alu16_core
// Description : Registered 16-bit ALU. Captures operands and opcode every
//               edge, computes the result combinationally from the captured
//               values and keeps the previous result for NOOP.
// Revision    : 1.0 - initial release
// ============================================================================
module alu16_core
    import alu16_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input wire     clk,
    input wire     reset,
    alu16_if.slave bus
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_select;
    logic [WIDTH-1:0] r_prev;

    logic [WIDTH-1:0] w_result;
    logic             w_error;
    logic             w_clear;

    // A registered CLEAR zeroes the operand and history registers on the next edge.
    assign w_clear = (r_select == OP_CLEAR);

    // Operand, opcode and history capture; reset overrides everything, clear spares select.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_select <= '0;
            r_prev   <= '0;
        end else begin
            r_select <= bus.opcode;
            if (w_clear) begin
                r_a    <= '0;
                r_b    <= '0;
                r_prev <= '0;
            end else begin
                r_a    <= bus.a_in;
                r_b    <= bus.b_in;
                r_prev <= w_result;
            end
        end
    end

    alu16_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_select (r_select),
        .i_prev   (r_prev),
        .o_result (w_result),
        .o_error  (w_error)
    );

    assign bus.a            = r_a;
    assign bus.b            = r_b;
    assign bus.select       = r_select;
    assign bus.prev_output  = r_prev;
    assign bus.final_output = w_result;
    assign bus.error        = w_error;

endmodule
`default_nettype wire

// File: tb/tb_alu16_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu16_core
// Description : Directed-vector self-checking bench for alu16_core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu16_core;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu16_if #(.WIDTH(16)) bus ();

    alu16_core #(
        .WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present inputs, then sample just after the capturing edge.
    task automatic step(input logic [15:0] av, input logic [15:0] bv, input logic [3:0] op);
        @(negedge clk);
        bus.a_in   = av;
        bus.b_in   = bv;
        bus.opcode = op;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [15:0] res, input logic err);
        chk({tag, "_res"}, {16'h0, bus.final_output}, {16'h0, res});
        chk({tag, "_err"}, {31'h0, bus.error}, {31'h0, err});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.a_in   = 16'h1234;
        bus.b_in   = 16'h5678;
        bus.opcode = 4'h3;
        step(16'h1234, 16'h5678, 4'h3);
        step(16'h1234, 16'h5678, 4'h3);
        chk("rst_a",      {16'h0, bus.a},           32'h0);
        chk("rst_b",      {16'h0, bus.b},           32'h0);
        chk("rst_select", {28'h0, bus.select},      32'h0);
        chk("rst_prev",   {16'h0, bus.prev_output}, 32'h0);
        chk_res("rst", 16'h0, 1'b0);

        reset = 1'b0;
        step(16'd40000, 16'd5, 4'd13);
        chk("div_a", {16'h0, bus.a}, 32'd40000);
        chk_res("div", 16'd8000, 1'b0);

        step(16'd1, 16'd1, 4'd0);
        chk("noop_sel",  {28'h0, bus.select},      32'h0);
        chk("noop_prev", {16'h0, bus.prev_output}, 32'd8000);
        chk_res("noop", 16'd8000, 1'b0);

        step(16'd7, 16'd7, 4'd15);
        chk("clr_sel",  {28'h0, bus.select},      32'hF);
        chk("clr_prev", {16'h0, bus.prev_output}, 32'd8000);
        chk_res("clr", 16'h0, 1'b0);

        step(16'd9, 16'd9, 4'd0);
        chk("clr2_a",    {16'h0, bus.a},           32'h0);
        chk("clr2_b",    {16'h0, bus.b},           32'h0);
        chk("clr2_prev", {16'h0, bus.prev_output}, 32'h0);
        chk("clr2_sel",  {28'h0, bus.select},      32'h0);
        chk_res("clr2", 16'h0, 1'b0);

        step(16'd200, 16'd1000, 4'd5);
        chk_res("mul_ovf", 16'd3392, 1'b1);
        step(16'd300, 16'd200, 4'd5);
        chk_res("mul", 16'd60000, 1'b0);

        step(16'd32, 16'd5, 4'd6);
        chk_res("srl", 16'd1, 1'b0);
        step(16'h8000, 16'h0013, 4'd6);
        chk_res("srl_hi", 16'h1000, 1'b0);
        step(16'd2, 16'd4, 4'd14);
        chk_res("sll", 16'd32, 1'b0);
        step(16'h8001, 16'h0011, 4'd14);
        chk_res("sll_wrap", 16'h0002, 1'b0);

        step(16'd15, 16'd9, 4'd8);
        chk_res("mod", 16'd6, 1'b0);
        step(16'd100, 16'd7, 4'd8);
        chk_res("mod2", 16'd2, 1'b0);
        step(16'd100, 16'd7, 4'd13);
        chk_res("div2", 16'd14, 1'b0);
        step(16'hFFFF, 16'h0001, 4'd13);
        chk_res("div_max", 16'hFFFF, 1'b0);
        step(16'd15, 16'd0, 4'd8);
        chk_res("mod_z", 16'h0, 1'b1);
        step(16'd15, 16'd0, 4'd13);
        chk_res("div_z", 16'h0, 1'b1);

        step(16'hFFFF, 16'd1, 4'd4);
        chk_res("add_c", 16'h0, 1'b1);
        step(16'd1000, 16'd2345, 4'd4);
        chk_res("add", 16'd3345, 1'b0);
        step(16'd3, 16'd5, 4'd12);
        chk_res("sub_b", 16'hFFFE, 1'b1);
        step(16'd10, 16'd3, 4'd12);
        chk_res("sub", 16'd7, 1'b0);

        step(16'hF0F0, 16'hFF00, 4'd1);
        chk_res("and", 16'hF000, 1'b0);
        step(16'hF0F0, 16'hFF00, 4'd2);
        chk_res("or", 16'hFFF0, 1'b0);
        step(16'hF0F0, 16'hFF00, 4'd3);
        chk_res("xor", 16'h0FF0, 1'b0);
        step(16'hF0F0, 16'hFF00, 4'd9);
        chk_res("nand", 16'h0FFF, 1'b0);
        step(16'hF0F0, 16'hFF00, 4'd10);
        chk_res("nor", 16'h000F, 1'b0);
        step(16'hF0F0, 16'hFF00, 4'd11);
        chk_res("xnor", 16'hF00F, 1'b0);
        step(16'hF0F0, 16'hFF00, 4'd7);
        chk_res("not", 16'h0F0F, 1'b0);

        step(16'd5, 16'd6, 4'd15);
        chk("pre_rst_a", {16'h0, bus.a}, 32'd5);
        reset = 1'b1;
        step(16'd5, 16'd6, 4'd15);
        chk("rst2_a",      {16'h0, bus.a},           32'h0);
        chk("rst2_b",      {16'h0, bus.b},           32'h0);
        chk("rst2_select", {28'h0, bus.select},      32'h0);
        chk("rst2_prev",   {16'h0, bus.prev_output}, 32'h0);
        chk_res("rst2", 16'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
